xnor_popcount_acc: RTL and testbench

XNOR_POPCOUNT_ACC -- requirements
Module: xnor_popcount_acc

---
 rtl/xnor_pop_pkg.sv | 26 ++
 rtl/xnor_popcount_acc_if.sv | 29 ++
 rtl/xnor_popcount_lane.sv | 37 +++
 rtl/xnor_popcount_acc.sv | 138 +++++++++++++
 tb/tb_xnor_popcount_acc.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xnor_pop_pkg.sv
// Shared types and width/saturation helpers for the XNOR-popcount accumulator.
package xnor_pop_pkg;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int pop_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic longint sat_umax(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint sat_smax(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_smin(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/xnor_popcount_acc_if.sv
// Beat-in / result-out bus of the XNOR-popcount accumulator.
interface xnor_popcount_acc_if #(
    parameter int N       = 256,
    parameter int CH      = 4,
    parameter int ACC_W   = 16,
    parameter int BEATS_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          in_x;
    logic [CH*N-1:0]       in_w;
    logic [CH*ACC_W-1:0]   in_thr;
    logic [BEATS_W-1:0]    cfg_beats;
    logic                  cfg_bipolar;
    logic                  out_valid;
    logic                  out_ready;
    logic [CH*ACC_W-1:0]   out_sum;
    logic [CH-1:0]         out_bits;

    modport master (
        output in_valid, in_x, in_w, in_thr, cfg_beats, cfg_bipolar, out_ready,
        input  in_ready, out_valid, out_sum, out_bits
    );

    modport slave (
        input  in_valid, in_x, in_w, in_thr, cfg_beats, cfg_bipolar, out_ready,
        output in_ready, out_valid, out_sum, out_bits
    );
endinterface

// File: rtl/xnor_popcount_lane.sv
// One output channel: XNOR against the shared activation, popcount, map to the
// unipolar/bipolar term and register it (pipeline stage 1).
module xnor_popcount_lane
    import xnor_pop_pkg::*;
#(
    parameter int N  = 256,
    parameter int TW = pop_w(N) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic                 i_bipolar,
    input  logic [N-1:0]         i_x,
    input  logic [N-1:0]         i_w,
    output logic signed [TW-1:0] o_term
);
    localparam int PW = pop_w(N);

    logic [PW-1:0]         w_pop;
    logic signed [TW-1:0]  w_term;
    logic signed [TW-1:0]  r_term;

    // 2*pop-N needs one bit more than pop; computed in int then truncated
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) w_pop = w_pop + PW'(i_x[i] ~^ i_w[i]);
        w_term = i_bipolar ? TW'(2 * int'(w_pop) - N) : TW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn || i_clr) r_term <= '0;
        else if (i_en)      r_term <= w_term;
    end

    assign o_term = r_term;
endmodule

// File: rtl/xnor_popcount_acc.sv
// Binary-NN neuron block: CH channels accumulate XNOR-popcount terms over a
// configurable number of beats, then present saturated sums and threshold bits.
module xnor_popcount_acc
    import xnor_pop_pkg::*;
#(
    parameter int N       = 256,
    parameter int CH      = 4,
    parameter int ACC_W   = 16,
    parameter int BEATS_W = 8
) (
    input logic               clk,
    input logic               rstn,
    xnor_popcount_acc_if.slave bus
);
    localparam int TW = pop_w(N) + 1;
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] UMAX = SW'(sat_umax(ACC_W));
    localparam logic signed [SW-1:0] SMAX = SW'(sat_smax(ACC_W));
    localparam logic signed [SW-1:0] SMIN = SW'(sat_smin(ACC_W));

    state_t                     r_state;
    logic [BEATS_W-1:0]         r_cnt, r_beats;
    logic                       r_bip, r_s1_vld, r_out_valid;
    logic [CH-1:0][ACC_W-1:0]   r_acc, r_thr, r_sum;
    logic [CH-1:0]              r_bits;

    logic [CH-1:0][TW-1:0]      w_term;
    logic [CH-1:0][ACC_W-1:0]   w_acc_nxt;
    logic [CH-1:0]              w_bits;
    logic [BEATS_W-1:0]         w_beats_in;
    logic                       w_first, w_last, w_bip_eff;
    logic                       w_in_ready, w_fire, w_out_fire;

    // Extend both operands two bits so the raw sum never wraps before clamping
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [TW-1:0]    t,
                                                 input logic             bip);
        logic signed [SW-1:0] a, s;
        a = bip ? $signed({{2{acc[ACC_W-1]}}, acc}) : $signed({2'b00, acc});
        s = a + $signed({{(SW-TW){t[TW-1]}}, t});
        if (bip) begin
            if (s > SMAX)      s = SMAX;
            else if (s < SMIN) s = SMIN;
        end else if (s > UMAX) begin
            s = UMAX;
        end
        return s[ACC_W-1:0];
    endfunction

    assign w_beats_in = (bus.cfg_beats == '0) ? BEATS_W'(1) : bus.cfg_beats;
    assign w_first    = (r_cnt == '0);
    assign w_bip_eff  = w_first ? bus.cfg_bipolar : r_bip;
    assign w_last     = w_first ? (w_beats_in == BEATS_W'(1))
                                : (r_cnt == r_beats - BEATS_W'(1));
    assign w_in_ready = rstn && (r_state == S_ACC);
    assign w_fire     = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    always_comb begin
        w_acc_nxt = '0;
        w_bits    = '0;
        for (int c = 0; c < CH; c++) begin
            w_acc_nxt[c] = sat_add(r_acc[c], w_term[c], r_bip);
            w_bits[c]    = r_bip ? ($signed(w_acc_nxt[c]) > $signed(r_thr[c]))
                                 : (w_acc_nxt[c] > r_thr[c]);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        xnor_popcount_lane #(.N(N), .TW(TW)) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .i_clr     (w_out_fire),
            .i_en      (w_fire),
            .i_bipolar (w_bip_eff),
            .i_x       (bus.in_x),
            .i_w       (bus.in_w[c*N +: N]),
            .o_term    (w_term[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_ACC;
            r_cnt       <= '0;
            r_beats     <= '0;
            r_bip       <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_acc       <= '0;
            r_thr       <= '0;
            r_sum       <= '0;
            r_bits      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    r_s1_vld <= w_fire;
                    if (r_s1_vld) r_acc <= w_acc_nxt;
                    if (w_fire) begin
                        if (w_first) begin
                            r_beats <= w_beats_in;
                            r_bip   <= bus.cfg_bipolar;
                        end
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_thr   <= bus.in_thr;
                            r_state <= S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                // Last beat's term is still in stage 1; fold it in and publish
                S_DRAIN: begin
                    r_acc       <= w_acc_nxt;
                    r_sum       <= w_acc_nxt;
                    r_bits      <= w_bits;
                    r_s1_vld    <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_acc       <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_ACC;
                    end
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_bits  = r_bits;
endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Drives a 16-bit and a 12-bit accumulator instance in lockstep and compares
// both against a beat-list reference model.
module tb_xnor_popcount_acc;
    localparam int N = 256, CH = 4, BW = 8, AW0 = 16, AW1 = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   nvec = 0, nerr = 0;

    logic [N-1:0]    qx[$];
    logic [CH*N-1:0] qw[$];
    longint          thr_c[CH];
    longint          exp0[CH], exp1[CH];
    logic [CH-1:0]   eb0, eb1;

    always #5 clk = ~clk;

    xnor_popcount_acc_if #(.N(N), .CH(CH), .ACC_W(AW0), .BEATS_W(BW)) if0();
    xnor_popcount_acc_if #(.N(N), .CH(CH), .ACC_W(AW1), .BEATS_W(BW)) if1();

    xnor_popcount_acc #(.N(N), .CH(CH), .ACC_W(AW0), .BEATS_W(BW)) u0 (.clk(clk), .rstn(rstn), .bus(if0));
    xnor_popcount_acc #(.N(N), .CH(CH), .ACC_W(AW1), .BEATS_W(BW)) u1 (.clk(clk), .rstn(rstn), .bus(if1));

    task automatic chk(input string tag, input longint got, input longint exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic longint sval(input longint raw, input int aw, input bit sgn);
        longint v;
        v = raw & ((longint'(1) << aw) - 1);
        if (sgn && v[aw-1]) v -= (longint'(1) << aw);
        return v;
    endfunction

    function automatic longint sat(input longint v, input int aw, input bit bip);
        longint hi, lo;
        hi = bip ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
        lo = bip ? -(longint'(1) << (aw - 1)) : 0;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic logic [N-1:0] rvec();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [CH*N-1:0] rw();
        logic [CH*N-1:0] v;
        for (int c = 0; c < CH; c++) v[c*N +: N] = rvec();
        return v;
    endfunction

    // Reference: per channel, sum pop or 2*pop-N over the queued beats, clamping each step
    task automatic model(input bit bip);
        for (int c = 0; c < CH; c++) begin
            longint a0, a1, t;
            int pop;
            logic [CH*N-1:0] wv;
            a0 = 0; a1 = 0;
            for (int b = 0; b < qx.size(); b++) begin
                wv  = qw[b];
                pop = $countones(~(qx[b] ^ wv[c*N +: N]));
                t   = bip ? longint'(2 * pop - N) : longint'(pop);
                a0  = sat(a0 + t, AW0, bip);
                a1  = sat(a1 + t, AW1, bip);
            end
            exp0[c] = a0;
            exp1[c] = a1;
            eb0[c]  = a0 > sval(thr_c[c], AW0, bip);
            eb1[c]  = a1 > sval(thr_c[c], AW1, bip);
        end
    endtask

    task automatic drive(input logic [N-1:0] x, input logic [CH*N-1:0] w, input logic v,
                         input int cfgb, input logic bip);
        if0.in_valid = v;        if1.in_valid = v;
        if0.in_x = x;            if1.in_x = x;
        if0.in_w = w;            if1.in_w = w;
        if0.cfg_beats = BW'(cfgb); if1.cfg_beats = BW'(cfgb);
        if0.cfg_bipolar = bip;   if1.cfg_bipolar = bip;
        for (int c = 0; c < CH; c++) begin
            if0.in_thr[c*AW0 +: AW0] = AW0'(thr_c[c]);
            if1.in_thr[c*AW1 +: AW1] = AW1'(thr_c[c]);
        end
    endtask

    task automatic check_out(input string tag, input bit bip);
        for (int c = 0; c < CH; c++) begin
            chk({tag, "_sum16"}, sval(longint'(if0.out_sum[c*AW0 +: AW0]), AW0, bip), exp0[c]);
            chk({tag, "_sum12"}, sval(longint'(if1.out_sum[c*AW1 +: AW1]), AW1, bip), exp1[c]);
        end
        chk({tag, "_bits16"}, longint'(if0.out_bits), longint'(eb0));
        chk({tag, "_bits12"}, longint'(if1.out_bits), longint'(eb1));
    endtask

    task automatic handshake();
        @(negedge clk);
        if0.out_ready = 1'b1; if1.out_ready = 1'b1;
        if0.in_valid  = 1'b0; if1.in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("hs_vld", longint'(if0.out_valid | if1.out_valid), 0);
        chk("hs_rdy", longint'(if0.in_ready & if1.in_ready), 1);
        @(negedge clk);
        if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    endtask

    // Feeds the queued beats back-to-back; later beats carry junk cfg to prove it is latched
    task automatic apply(input string tag, input int cfgb, input bit bip, input bit hold);
        int cyc;
        model(bip);
        for (int b = 0; b < qx.size(); b++) begin
            @(negedge clk);
            if (b == 0) drive(qx[b], qw[b], 1'b1, cfgb, bip);
            else        drive(qx[b], qw[b], 1'b1, int'($urandom_range(0, 255)), 1'($urandom));
            cyc = 0;
            while (!(if0.in_ready && if1.in_ready) && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk({tag, "_rdywait"}, cyc, 0);
            @(posedge clk);
        end
        #1;
        chk({tag, "_vld_early"}, longint'(if0.out_valid | if1.out_valid), 0);
        chk({tag, "_rdy_drain"}, longint'(if0.in_ready | if1.in_ready), 0);
        @(negedge clk);
        if0.in_valid = 1'b0; if1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_vld_lat"}, longint'(if0.out_valid & if1.out_valid), 1);
        check_out(tag, bip);
        if (!hold) handshake();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]    x, v;
        logic [CH*N-1:0] w;
        int              nb, cfgb;
        bit              bip;

        for (int c = 0; c < CH; c++) thr_c[c] = 0;
        if0.out_ready = 1'b0; if1.out_ready = 1'b0;
        drive('0, '0, 1'b0, 1, 1'b0);

        // reset held for three edges
        rstn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rdy", longint'(if0.in_ready | if1.in_ready), 0);
            chk("rst_vld", longint'(if0.out_valid | if1.out_valid), 0);
            chk("rst_sum16", longint'(if0.out_sum), 0);
            chk("rst_sum12", longint'(if1.out_sum), 0);
            chk("rst_bits", longint'(if0.out_bits | if1.out_bits), 0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy", longint'(if0.in_ready & if1.in_ready), 1);
        chk("rel_vld", longint'(if0.out_valid | if1.out_valid), 0);

        // directed unipolar single beat
        x = '1;
        w[0*N +: N] = '1;
        w[1*N +: N] = '0;
        w[2*N +: N] = {(N/2){2'b01}};
        w[3*N +: N] = '1;
        qx.delete(); qw.delete();
        qx.push_back(x); qw.push_back(w);
        for (int c = 0; c < CH; c++) thr_c[c] = 127;
        apply("dir_uni", 1, 1'b0, 1'b1);
        chk("dir_uni_s0", longint'(if0.out_sum[0*AW0 +: AW0]), 256);
        chk("dir_uni_s1", longint'(if0.out_sum[1*AW0 +: AW0]), 0);
        chk("dir_uni_s2", longint'(if0.out_sum[2*AW0 +: AW0]), 128);
        chk("dir_uni_bits", longint'(if0.out_bits), 13);
        handshake();

        // directed bipolar, four back-to-back beats
        qx.delete(); qw.delete();
        repeat (4) begin
            x = rvec(); w = rw();
            w[0 +: N] = x;
            w[N +: N] = ~x;
            qx.push_back(x); qw.push_back(w);
        end
        for (int c = 0; c < CH; c++) thr_c[c] = 0;
        apply("dir_bip", 4, 1'b1, 1'b1);
        chk("dir_bip_s0", sval(longint'(if0.out_sum[0 +: AW0]), AW0, 1'b1), 1024);
        chk("dir_bip_s1", sval(longint'(if0.out_sum[AW0 +: AW0]), AW0, 1'b1), -1024);
        chk("dir_bip_b01", longint'(if0.out_bits[1:0]), 1);
        handshake();

        // backpressure: result held while in_valid stays high
        qx.delete(); qw.delete();
        qx.push_back(rvec()); qw.push_back(rw());
        for (int c = 0; c < CH; c++) thr_c[c] = $urandom_range(0, N);
        apply("bp_res", 1, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            drive(rvec(), rw(), 1'b1, 1, 1'b0);
            @(posedge clk); #1;
            chk("bp_vld", longint'(if0.out_valid & if1.out_valid), 1);
            chk("bp_rdy", longint'(if0.in_ready | if1.in_ready), 0);
            check_out("bp_hold", 1'b0);
        end
        handshake();
        qx.delete(); qw.delete();
        qx.push_back(rvec()); qw.push_back(rw());
        bip = 1'($urandom);
        for (int c = 0; c < CH; c++) thr_c[c] = 0;
        apply("post_bp", 1, bip, 1'b0);

        // saturation (visible on the 12-bit instance)
        x = rvec();
        qx.delete(); qw.delete();
        repeat (16) begin qx.push_back(x); qw.push_back({CH{x}}); end
        for (int c = 0; c < CH; c++) thr_c[c] = 4000;
        apply("sat_uni", 16, 1'b0, 1'b1);
        chk("sat_uni12", sval(longint'(if1.out_sum[0 +: AW1]), AW1, 1'b0), 4095);
        handshake();
        qx.delete(); qw.delete();
        repeat (16) begin qx.push_back(x); qw.push_back({CH{~x}}); end
        for (int c = 0; c < CH; c++) thr_c[c] = 0;
        apply("sat_bip", 16, 1'b1, 1'b1);
        chk("sat_bip12", sval(longint'(if1.out_sum[0 +: AW1]), AW1, 1'b1), -2048);
        handshake();

        // reset in the middle of a 4-beat result
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive(rvec(), rw(), 1'b1, 4, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        rstn = 1'b0;
        if0.in_valid = 1'b0; if1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_rdy", longint'(if0.in_ready | if1.in_ready), 0);
        chk("mid_rst_vld", longint'(if0.out_valid | if1.out_valid), 0);
        @(negedge clk);
        rstn = 1'b1;
        v = '1;
        v[9:0] = '0;
        x = '0;
        qx.delete(); qw.delete();
        repeat (4) begin qx.push_back(x); qw.push_back({CH{v}}); end
        for (int c = 0; c < CH; c++) thr_c[c] = 39;
        apply("mid_rst", 4, 1'b0, 1'b1);
        chk("mid_rst_s0", longint'(if0.out_sum[0 +: AW0]), 40);
        handshake();

        // randomized results
        repeat (10) begin
            nb   = $urandom_range(1, 6);
            cfgb = nb;
            if (nb == 1 && $urandom_range(0, 1) == 1) cfgb = 0;
            bip  = 1'($urandom);
            qx.delete(); qw.delete();
            repeat (nb) begin
                x = rvec();
                if ($urandom_range(0, 1) == 1) w = {CH{x ^ (rvec() & rvec() & rvec())}};
                else                           w = rw();
                qx.push_back(x); qw.push_back(w);
            end
            for (int c = 0; c < CH; c++)
                thr_c[c] = bip ? longint'($urandom_range(0, 2 * nb * N)) - longint'(nb * N)
                               : longint'($urandom_range(0, nb * N));
            apply("rnd", cfgb, bip, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
